quad_step_decoder: RTL and testbench



---
 rtl/quad_step_decoder.sv | 130 +++++++++++++
 tb/tb_quad_step_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
`default_nettype none
// quad_step_decoder -- filtered quadrature A/B to step/direction decoder with loadable position count.
// Rev 1.0
module quad_step_decoder #(
  parameter int WIDTH    = 8,
  parameter int FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cha,
  input  logic             chb,
  input  logic             ld,
  input  logic [0:WIDTH-1] d_in,
  input  logic             err_clr,
  output logic             step,
  output logic             mode,
  output logic [0:WIDTH-1] count,
  output logic             err
);

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       raw;
  logic [1:0]       ph;
  logic [1:0]       busy;
  logic [1:0]       prev, prev_nxt;
  logic [1:0]       ph_fwd, ph_rev;
  logic [1:0]       warm;
  logic             step_nxt, mode_nxt, err_nxt;
  logic [0:WIDTH-1] count_nxt;

  assign raw = {cha, chb};

  // Bit 1 is channel A, bit 0 is channel B, so ph = {cha_f, chb_f}.
  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic       s1, s2, f;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        f   <= 1'b0;
        cnt <= 4'd0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 == f) begin
          cnt <= 4'd0;
        end else if (cnt == 4'(FILT_LEN - 1)) begin
          f   <= s2;
          cnt <= 4'd0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end

    assign ph[i]   = f;
    assign busy[i] = (cnt != 4'd0) || (s2 != f);
  end

  // The synchronisers hold their reset value for two edges; INIT must not
  // latch a phase until they carry real samples of the inputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) warm <= 2'b00;
    else     warm <= {warm[0], 1'b1};
  end

  assign ph_fwd = {prev[0], ~prev[1]};
  assign ph_rev = {~prev[0], prev[1]};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= INIT;
      prev  <= 2'b00;
      step  <= 1'b0;
      mode  <= 1'b1;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      prev  <= prev_nxt;
      step  <= step_nxt;
      mode  <= mode_nxt;
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    step_nxt  = 1'b0;
    mode_nxt  = mode;
    count_nxt = count;
    err_nxt   = err;
    if (err_clr) err_nxt = 1'b0;
    case (state)
      INIT: begin
        if (warm[1] && (busy == 2'b00)) begin
          prev_nxt  = ph;
          state_nxt = TRACK;
        end
      end
      TRACK: begin
        prev_nxt = ph;
        if (ph == ph_fwd) begin
          step_nxt  = 1'b1;
          mode_nxt  = 1'b1;
          count_nxt = count + WIDTH'(1);
        end else if (ph == ph_rev) begin
          step_nxt  = 1'b1;
          mode_nxt  = 1'b0;
          count_nxt = count - WIDTH'(1);
        end else if (ph != prev) begin
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
    if (ld) count_nxt = d_in;
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// tb_quad_step_decoder -- directed and randomized checks against a cycle-level reference model.
// Rev 1.0
module tb_quad_step_decoder;

  localparam int WIDTH    = 8;
  localparam int FILT_LEN = 3;

  logic             clk;
  logic             clr;
  logic             cha, chb;
  logic             ld;
  logic [0:WIDTH-1] d_in;
  logic             err_clr;
  logic             step;
  logic             mode;
  logic [0:WIDTH-1] count;
  logic             err;

  quad_step_decoder #(.WIDTH(WIDTH), .FILT_LEN(FILT_LEN)) dut (
    .clk    (clk),
    .clr    (clr),
    .cha    (cha),
    .chb    (chb),
    .ld     (ld),
    .d_in   (d_in),
    .err_clr(err_clr),
    .step   (step),
    .mode   (mode),
    .count  (count),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: raw sample history, filtered levels, and the decoded
  // position along the gray cycle 00,01,11,10.
  bit         qa[$];
  bit         qb[$];
  bit         fa, fb;
  int         run_a, run_b;
  bit         m_init;
  logic [1:0] m_prev;
  logic       m_step, m_mode, m_err;
  logic [7:0] m_count;
  int         pos[4] = '{0, 1, 3, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("step",  {31'd0, step},  {31'd0, m_step});
    check("mode",  {31'd0, mode},  {31'd0, m_mode});
    check("count", {24'd0, count}, {24'd0, m_count});
    check("err",   {31'd0, err},   {31'd0, m_err});
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    fa = 0; fb = 0; run_a = 0; run_b = 0;
    m_init = 1; m_prev = 2'b00;
    m_step = 0; m_mode = 1; m_count = 8'h00; m_err = 0;
  endtask

  task automatic model_edge();
    bit         sa, sb, busy, bad;
    logic [1:0] ph;
    int         d;
    // The filter at this edge sees the input as it was two edges earlier.
    sa   = (qa.size() >= 2) ? qa[qa.size()-2] : 1'b0;
    sb   = (qb.size() >= 2) ? qb[qb.size()-2] : 1'b0;
    ph   = {fa, fb};
    busy = (run_a != 0) || (run_b != 0) || (sa != fa) || (sb != fb);
    bad  = 0;
    m_step = 0;
    if (m_init) begin
      if (qa.size() >= 2 && !busy) begin
        m_prev = ph;
        m_init = 0;
      end
    end else begin
      d = (pos[ph] - pos[m_prev] + 4) % 4;
      if (d == 1) begin m_step = 1; m_mode = 1; m_count = m_count + 8'd1; end
      if (d == 3) begin m_step = 1; m_mode = 0; m_count = m_count - 8'd1; end
      bad = (d == 2);
      m_prev = ph;
    end
    if (err_clr) m_err = 0;
    if (bad) m_err = 1;
    if (ld) m_count = d_in;
    if (sa != fa) begin
      run_a++;
      if (run_a == FILT_LEN) begin fa = sa; run_a = 0; end
    end else run_a = 0;
    if (sb != fb) begin
      run_b++;
      if (run_b == FILT_LEN) begin fb = sb; run_b = 0; end
    end else run_b = 0;
    qa.push_back(cha);
    qb.push_back(chb);
    if (qa.size() > 4) void'(qa.pop_front());
    if (qb.size() > 4) void'(qb.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (step === 1'b1) pulses++;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    model_reset();
    #1;
    check_all();
    clr = 1'b0;
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    {cha, chb} = p;
    for (int k = 0; k < n; k++) tick();
  endtask

  int         first;
  logic [1:0] cur, nxt;
  int         sel;

  initial begin
    clr = 1'b0; ld = 1'b0; d_in = '0; err_clr = 1'b0;
    cha = 1'b1; chb = 1'b1;
    model_reset();
    #1;

    // Reset while sitting at phase 11, then hold it: no event may appear.
    do_clr();
    check("rst_count", {24'd0, count}, 32'h0);
    check("rst_mode",  {31'd0, mode},  32'h1);
    pulses = 0;
    hold(2'b11, 20);
    check("idle11_pulses", pulses, 0);
    check("idle11_err", {31'd0, err}, 32'h0);

    // Forward sequence from 00 with latency measurement.
    cha = 1'b0; chb = 1'b0;
    do_clr();
    hold(2'b00, 10);
    pulses = 0;
    first  = 0;
    {cha, chb} = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (step === 1'b1 && first == 0) first = k;
    end
    check("latency", first, 6);
    hold(2'b11, 8);
    hold(2'b10, 8);
    hold(2'b00, 8);
    check("fwd_pulses", pulses, 4);
    check("fwd_count", {24'd0, count}, 32'h04);
    check("fwd_mode", {31'd0, mode}, 32'h1);

    // Load then six reverse steps.
    ld = 1'b1; d_in = 8'h02;
    tick();
    ld = 1'b0;
    pulses = 0;
    hold(2'b10, 8); hold(2'b11, 8); hold(2'b01, 8);
    hold(2'b00, 8); hold(2'b10, 8); hold(2'b11, 8);
    check("rev_pulses", pulses, 6);
    check("rev_count", {24'd0, count}, 32'hFC);
    check("rev_mode", {31'd0, mode}, 32'h0);

    // Glitch rejection and minimum accepted pulse width.
    hold(2'b01, 8); hold(2'b00, 8);
    pulses = 0;
    hold(2'b10, 2); hold(2'b00, 8);
    check("glitch_pulses", pulses, 0);
    check("glitch_count", {24'd0, count}, 32'hFA);
    hold(2'b10, 3); hold(2'b00, 8);
    check("pulse3_pulses", pulses, 2);
    check("pulse3_count", {24'd0, count}, 32'hFA);

    // Illegal double change, sticky err, clear, then resume.
    pulses = 0;
    hold(2'b11, 8);
    check("illegal_err", {31'd0, err}, 32'h1);
    check("illegal_pulses", pulses, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr", {31'd0, err}, 32'h0);
    hold(2'b10, 8);
    check("resume_count", {24'd0, count}, 32'hFB);

    // Wrap, load priority over a step, and reset during a pulse.
    ld = 1'b1; d_in = 8'hFF;
    tick();
    ld = 1'b0;
    hold(2'b00, 8);
    check("wrap_count", {24'd0, count}, 32'h00);
    {cha, chb} = 2'b01;
    for (int k = 1; k <= 5; k++) tick();
    ld = 1'b1; d_in = 8'h7F;
    tick();
    ld = 1'b0;
    check("ldstep_count", {24'd0, count}, 32'h7F);
    check("ldstep_step", {31'd0, step}, 32'h1);
    check("ldstep_mode", {31'd0, mode}, 32'h1);
    do_clr();
    check("midclr_step", {31'd0, step}, 32'h0);
    check("midclr_count", {24'd0, count}, 32'h0);

    // Randomized walk: legal moves, illegal jumps, glitches, loads, clears.
    cur = 2'b01;
    for (int seg = 0; seg < 1200; seg++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70) nxt = ($urandom_range(0, 1) == 1) ? {cur[0], ~cur[1]} : {~cur[0], cur[1]};
      else if (sel < 78) nxt = ~cur;
      else nxt = cur ^ 2'(1 << $urandom_range(0, 1));
      {cha, chb} = nxt;
      for (int k = int'($urandom_range(1, 8)); k > 0; k--) begin
        ld      = ($urandom_range(0, 19) == 0);
        d_in    = 8'($urandom);
        err_clr = ($urandom_range(0, 15) == 0);
        tick();
      end
      ld = 1'b0; err_clr = 1'b0;
      if (sel >= 78 && $urandom_range(0, 1) == 1) hold(cur, int'($urandom_range(1, 6)));
      else cur = nxt;
      if ($urandom_range(0, 99) == 0) do_clr();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
